// File: rtl/memory_access_unit_pkg.sv
// rtl/memory_access_unit_pkg.sv - shared encodings and helpers for the load/store unit
package memory_access_unit_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } mem_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_RESP   = 3'd3,
    ST_FAULT  = 3'd4
  } lsu_state_e;

  function automatic logic [3:0] sel_size(input logic [2:0] sel);
    case (sel[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic sel_legal(input logic [2:0] sel, input int data_w);
    case (sel)
      MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU: return 1'b1;
      MEM_D, MEM_WU:                       return (data_w == 64);
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_unit_lane.sv
// rtl/memory_access_unit_lane.sv - byte strobes, store lane shift and load extract/extend
module memory_access_unit_lane
  import memory_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                          beat,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [2:0]                    sel,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [2*DATA_W-1:0]           line,
  output logic [DATA_W/8-1:0]           strobe,
  output logic [DATA_W-1:0]             lane_wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int NB = DATA_W / 8;
  localparam logic [2*NB-1:0] ONE_M = 1;

  logic [2*NB-1:0]     mask_w;
  logic [2*DATA_W-1:0] wdata_w;
  logic [DATA_W-1:0]   raw;

  // Work on a double-width window: the low half is beat 0, the high half beat 1.
  always_comb begin
    mask_w     = ((ONE_M << sel_size(sel)) - ONE_M) << offset;
    wdata_w    = {{DATA_W{1'b0}}, wdata} << {offset, 3'b000};
    strobe     = beat ? mask_w[2*NB-1:NB] : mask_w[NB-1:0];
    lane_wdata = beat ? wdata_w[2*DATA_W-1:DATA_W] : wdata_w[DATA_W-1:0];
    raw        = DATA_W'(line >> {offset, 3'b000});
    case (sel)
      MEM_B:   rdata = DATA_W'($signed(raw[7:0]));
      MEM_BU:  rdata = DATA_W'(raw[7:0]);
      MEM_H:   rdata = DATA_W'($signed(raw[15:0]));
      MEM_HU:  rdata = DATA_W'(raw[15:0]);
      MEM_W:   rdata = DATA_W'($signed(raw[31:0]));
      MEM_WU:  rdata = DATA_W'(raw[31:0]);
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/memory_access_unit_lsu.sv
// rtl/memory_access_unit_lsu.sv - single-outstanding load/store unit with split misaligned beats
module memory_access_unit_lsu
  import memory_access_unit_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          mem_sel,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic                bus_re,
  output logic [DATA_W/8-1:0] bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e          state_q, state_d;
  logic                beat_q, beat_d;
  logic                we_q, we_d;
  logic                cross_q, cross_d;
  logic                err_q, err_d;
  logic [2:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2*DATA_W-1:0] line_q, line_d;

  logic                in_legal, in_cross;
  logic [NB-1:0]       lane_strobe;
  logic [DATA_W-1:0]   lane_wdata, lane_rdata;
  logic [ADDR_W-1:0]   base_addr;

  assign in_legal  = sel_legal(mem_sel, DATA_W);
  assign in_cross  = (int'(mem_addr[OFF_W-1:0]) + int'(sel_size(mem_sel))) > NB;
  assign base_addr = addr_q & ~ADDR_W'(NB - 1);

  memory_access_unit_lane #(.DATA_W(DATA_W)) u_lane (
    .beat       (beat_q),
    .offset     (addr_q[OFF_W-1:0]),
    .sel        (sel_q),
    .wdata      (wdata_q),
    .line       (line_q),
    .strobe     (lane_strobe),
    .lane_wdata (lane_wdata),
    .rdata      (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 1'b0;
      we_q    <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      cross_q <= cross_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    we_d    = we_q;
    cross_d = cross_q;
    err_d   = err_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          sel_d   = mem_sel;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cross_d = in_cross;
          beat_d  = 1'b0;
          err_d   = 1'b0;
          line_d  = '0;
          if (!in_legal || (in_cross && !MISALIGN_SPLIT)) state_d = ST_FAULT;
          else                                            state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus_gnt) begin
          if (!we_q) begin
            state_d = ST_WAIT_R;
          end else if (bus_err) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (cross_q && !beat_q) begin
            beat_d  = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT_R: begin
        if (bus_rvalid) begin
          if (beat_q) line_d[2*DATA_W-1:DATA_W] = bus_rdata;
          else        line_d[DATA_W-1:0]        = bus_rdata;
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (cross_q && !beat_q) begin
            beat_d  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP, ST_FAULT: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Bus fields are forced to zero outside ISSUE so idle and reset look identical.
  always_comb begin
    req_ready = 1'b0;
    bus_req   = 1'b0;
    bus_re    = 1'b0;
    bus_we    = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_rdata = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ISSUE: begin
        bus_req  = 1'b1;
        bus_re   = !we_q;
        bus_addr = base_addr + (beat_q ? ADDR_W'(NB) : '0);
        if (we_q) begin
          bus_we    = lane_strobe;
          bus_wdata = lane_wdata;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q) mem_rdata = lane_rdata;
      end
      ST_FAULT: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_access_unit_lsu.sv
// tb/tb_memory_access_unit_lsu.sv - directed self-checking bench for memory_access_unit_lsu
module tb_memory_access_unit_lsu;
  import memory_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid0, req_we;
  logic [2:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata;
  logic        bus_gnt, bus_gnt0, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  logic        req_ready, rsp_valid, rsp_err, bus_req, bus_re;
  logic [31:0] mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_we;

  logic        req_ready0, rsp_valid0, rsp_err0, bus_req0, bus_re0;
  logic [31:0] mem_rdata0, bus_addr0, bus_wdata0;
  logic [3:0]  bus_we0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access_unit_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .mem_rdata(mem_rdata), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  memory_access_unit_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rsp_valid(rsp_valid0),
    .rsp_err(rsp_err0), .mem_rdata(mem_rdata0), .bus_req(bus_req0), .bus_gnt(bus_gnt0),
    .bus_re(bus_re0), .bus_we(bus_we0), .bus_addr(bus_addr0), .bus_wdata(bus_wdata0),
    .bus_rvalid(1'b0), .bus_rdata(bus_rdata), .bus_err(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] wd);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load1(input string tag, input logic [2:0] sel, input logic [31:0] addr,
                       input logic [31:0] rd, input logic [31:0] exp);
    start(1'b0, sel, addr, 32'h0);
    chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_re"}, bus_re, 1);
    chk({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
    chk({tag, "_busy"}, req_ready, 0);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk({tag, "_req_drop"}, bus_req, 0);
    bus_rvalid = 1'b1; bus_rdata = rd; tick(); bus_rvalid = 1'b0;
    chk({tag, "_rsp"}, rsp_valid, 1);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_data"}, mem_rdata, exp);
    tick();
    chk({tag, "_rsp_end"}, rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0; mem_sel = MEM_W;
    mem_addr = '0; mem_wdata = '0; bus_gnt = 1'b0; bus_gnt0 = 1'b0; bus_rvalid = 1'b0;
    bus_err = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_re", bus_re, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    rst_n = 1'b1;
    tick();

    load1("lw_aligned", MEM_W, 32'h100, 32'h8765_4321, 32'h8765_4321);
    load1("lb", MEM_B, 32'h103, 32'h8012_3456, 32'hFFFF_FF80);
    load1("lbu", MEM_BU, 32'h103, 32'h8012_3456, 32'h0000_0080);
    load1("lh_inword", MEM_H, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
    load1("lhu_inword", MEM_HU, 32'h102, 32'h8001_1234, 32'h0000_8001);

    // Single-beat byte store
    start(1'b1, MEM_B, 32'h101, 32'h1234_565A);
    chk("sb_req", bus_req, 1);
    chk("sb_re", bus_re, 0);
    chk("sb_addr", bus_addr, 32'h100);
    chk("sb_we", bus_we, 4'b0010);
    chk("sb_wdata", bus_wdata, 32'h3456_5A00);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk("sb_rsp", rsp_valid, 1);
    chk("sb_err", rsp_err, 0);
    chk("sb_rdata", mem_rdata, 0);
    tick();

    // Crossing word store, split into two beats
    start(1'b1, MEM_W, 32'h102, 32'hAABB_CCDD);
    chk("sw_x_b0_addr", bus_addr, 32'h100);
    chk("sw_x_b0_we", bus_we, 4'b1100);
    chk("sw_x_b0_wdata", bus_wdata, 32'hCCDD_0000);
    bus_gnt = 1'b1; tick();
    chk("sw_x_b1_req", bus_req, 1);
    chk("sw_x_b1_addr", bus_addr, 32'h104);
    chk("sw_x_b1_we", bus_we, 4'b0011);
    chk("sw_x_b1_wdata", bus_wdata, 32'h0000_AABB);
    chk("sw_x_b1_norsp", rsp_valid, 0);
    tick(); bus_gnt = 1'b0;
    chk("sw_x_rsp", rsp_valid, 1);
    chk("sw_x_err", rsp_err, 0);
    tick();

    // Crossing word load assembled from two beats
    start(1'b0, MEM_W, 32'h103, 32'h0);
    chk("lw_x_b0_addr", bus_addr, 32'h100);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344; tick(); bus_rvalid = 1'b0;
    chk("lw_x_b1_req", bus_req, 1);
    chk("lw_x_b1_addr", bus_addr, 32'h104);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h5566_7788; tick(); bus_rvalid = 1'b0;
    chk("lw_x_rsp", rsp_valid, 1);
    chk("lw_x_data", mem_rdata, 32'h6677_8811);
    tick();

    // Bus error on beat 0 aborts beat 1
    start(1'b0, MEM_W, 32'h101, 32'h0);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFF_FFFF; tick();
    bus_rvalid = 1'b0; bus_err = 1'b0;
    chk("berr_rsp", rsp_valid, 1);
    chk("berr_err", rsp_err, 1);
    chk("berr_rdata", mem_rdata, 0);
    chk("berr_no_b1", bus_req, 0);
    tick();
    chk("berr_no_b1_late", bus_req, 0);
    chk("berr_ready", req_ready, 1);

    // Illegal encodings fault immediately
    start(1'b0, 3'b111, 32'h100, 32'h0);
    chk("ill_rsp", rsp_valid, 1);
    chk("ill_err", rsp_err, 1);
    chk("ill_no_req", bus_req, 0);
    tick();
    start(1'b0, MEM_D, 32'h100, 32'h0);
    chk("dbl32_err", rsp_err, 1);
    chk("dbl32_no_req", bus_req, 0);
    tick();

    // MISALIGN_SPLIT=0: crossing faults, aligned still works
    chk("ns_ready", req_ready0, 1);
    req_valid0 = 1'b1; req_we = 1'b0; mem_sel = MEM_H; mem_addr = 32'h103; tick(); req_valid0 = 1'b0;
    chk("ns_x_no_req", bus_req0, 0);
    chk("ns_x_rsp", rsp_valid0, 1);
    chk("ns_x_err", rsp_err0, 1);
    chk("ns_x_rdata", mem_rdata0, 0);
    tick();
    req_valid0 = 1'b1; req_we = 1'b1; mem_sel = MEM_W; mem_addr = 32'h108;
    mem_wdata = 32'h0102_0304; tick(); req_valid0 = 1'b0;
    chk("ns_sw_req", bus_req0, 1);
    chk("ns_sw_we", bus_we0, 4'b1111);
    bus_gnt0 = 1'b1; tick(); bus_gnt0 = 1'b0;
    chk("ns_sw_rsp", rsp_valid0, 1);
    chk("ns_sw_err", rsp_err0, 0);
    tick();

    // Reset while waiting for read data
    start(1'b0, MEM_W, 32'h200, 32'h0);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    chk("rstw_busy", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rstw_bus_req", bus_req, 0);
    chk("rstw_ready", req_ready, 1);
    chk("rstw_rsp", rsp_valid, 0);
    tick(); rst_n = 1'b1; tick();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; tick(); bus_rvalid = 1'b0;
    chk("stale_rsp", rsp_valid, 0);
    chk("stale_ready", req_ready, 1);
    load1("after_rst", MEM_W, 32'h200, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_unit_lsu.md
# memory_access_unit_lsu

Parametrised load/store unit between the execute stage and the data bus. It accepts one memory request at a time over a valid/ready handshake and drives a req/gnt data bus with byte strobes. It sign- or zero-extends load data and splits boundary-crossing misaligned accesses into two bus beats. It returns a single-cycle response with an error flag.

## Interface
- DATA_W, 32: data/bus width. Legal values are 32 and 64.
- ADDR_W, 32: address width.
- MISALIGN_SPLIT, 1: controls boundary-crossing accesses. 1 splits them into two beats. 0 faults them with no bus activity.
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  unit idle; a request is accepted on req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- mem_sel  in  3  access size/sign, using the package encodings.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  fault. Qualified by rsp_valid.
- mem_rdata  out  DATA_W  extended load data. 0 for stores and errors.
- bus_req  out  1  beat request.
- bus_gnt  in  1  beat accepted.
- bus_re  out  1  read beat.
- bus_we  out  DATA_W/8  byte write strobes.
- bus_addr  out  ADDR_W  aligned beat address; low log2(DATA_W/8) bits are 0.
- bus_wdata  out  DATA_W  lane-shifted store data.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  DATA_W  read data.
- bus_err  in  1  bus fault. Sampled with bus_gnt for writes and with bus_rvalid for reads.

## Operation
- mem_sel encodings:
  - 3'b000 BYTE_SIGNED, 3'b001 HALF_SIGNED, 3'b010 WORD, 3'b011 DOUBLE.
  - 3'b100 BYTE_UNSIGNED, 3'b101 HALF_UNSIGNED, 3'b110 WORD_UNSIGNED.
  - DOUBLE and WORD_UNSIGNED are legal only when DATA_W=64.
  - Any other value is illegal. An illegal value gives rsp_err=1 with no bus beat.
- Terms: offset = addr mod (DATA_W/8); size = access bytes.
- Crossing: offset + size > DATA_W/8. Misalignment that stays inside one bus word uses a single beat.
- FSM:
  - IDLE: req_ready=1. On accept, latch the request. Go to FAULT if mem_sel is illegal, or if crossing with MISALIGN_SPLIT=0. Otherwise go to ISSUE with beat=0.
  - ISSUE: bus_req=1; address, strobes and data are held stable until bus_gnt.
    - On gnt for a write: if bus_err go to RESP with err; else if more beats, beat=1 and stay in ISSUE; else go to RESP.
    - On gnt for a read: go to WAIT_R.
  - WAIT_R: wait for bus_rvalid, then capture the beat's bytes. If bus_err go to RESP with err; else if more beats go to ISSUE with beat=1; else go to RESP.
  - FAULT, RESP: assert rsp_valid for one cycle, then go to IDLE.
- Beat 0:
  - bus_addr = aligned address.
  - Strobes cover bytes offset up to min(offset+size, DATA_W/8)-1.
  - bus_wdata = wdata << 8*offset.
- Beat 1:
  - bus_addr = aligned address + DATA_W/8.
  - Strobes cover the remaining low bytes.
  - bus_wdata = wdata >> 8*(DATA_W/8 - offset).
- Load assembly: beat-0 upper bytes form the low part of the result; beat-1 low bytes form the high part. The result is then sign- or zero-extended per mem_sel.
- Aborts: an error on beat 0 aborts beat 1. A bus_rvalid while not in WAIT_R is ignored.
- Reset values: req_ready=1, bus_req=0, bus_re=0, bus_we=0, bus_addr=0, bus_wdata=0, rsp_valid=0, rsp_err=0, mem_rdata=0.
- Reset mid-operation: all outputs return to reset values asynchronously and the request is dropped. A stale bus_rvalid arriving after reset is ignored.

## Timing
- Accept at cycle T. bus_req is registered and rises at T+1.
- A single-beat load with gnt at T+1 and rvalid at T+2 gives rsp_valid at T+3.
- A single-beat store with gnt at T+1 gives rsp_valid at T+2.
- Each extra beat adds at least 1 cycle for writes and 2 cycles for reads.
- FAULT responds at T+1.
- Throughput is one request in flight. req_ready is low from T+1 until the cycle after rsp_valid. The next accept can happen in the cycle after rsp_valid.
- The response side has no backpressure.
- bus_rvalid may arrive 1 or more cycles after gnt, never in the gnt cycle.

## Structure
- Package memory_access_unit_pkg holds:
  - mem_sel encodings, replacing MEM_SEL_ENUM;
  - FSM state encodings IDLE/ISSUE/WAIT_R/RESP/FAULT;
  - a size-from-mem_sel function.
- Sub-module memory_access_unit_lane: combinational strobe generation, write-lane shift and load extract/extend, parametrised by DATA_W.

## Test plan
- Aligned LW: addr 0x100, bus_rdata 0x8765_4321, gnt at T+1, rvalid at T+2 -> rsp_valid at T+3, mem_rdata 0x8765_4321, rsp_err=0.
- LB/LBU: addr 0x103, bus_rdata 0x80xx_xxxx -> LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- Crossing SW with DATA_W=32 and split=1: addr 0x102, wdata 0xAABB_CCDD -> two beats:
  - beat 0 at 0x100, we=4'b1100, wdata 0xCCDD_xxxx;
  - beat 1 at 0x104, we=4'b0011, wdata 0xxxxx_AABB.
- Crossing LH with split=0: addr 0x103 -> no bus_req, rsp_valid at T+1 with rsp_err=1 and mem_rdata 0.
- bus_err on beat 0 of a crossing LW -> no beat 1, rsp_err=1.
- rst_n low while in WAIT_R -> bus_req=0 immediately; a later rvalid is ignored; the next request completes normally.
